// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command parser.
// Opcode, error codes, ASCII bytes and the parser state encoding.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  localparam logic [1:0] ERR_BAD_CHAR = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_MISSING  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] SLASH = 8'h2F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPA   = 3'd1,
    S_OPB   = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4
  } parser_state_e;

  // Only called for bytes already classified as operators.
  function automatic opcode_e op_of(input logic [7:0] c);
    case (c)
      PLUS:    return OP_ADD;
      MINUS:   return OP_SUB;
      STAR:    return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator shared by operands A and B.
// Range limit depends on CALC_PARSER_SIGNED_EN (signed magnitudes) or not (unsigned).
module dec_accum #(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         digit_en,
  input  logic [3:0]   digit,
  input  logic         neg,
  output logic [W-1:0] value,
  output logic         overflow,
  output logic         has_digits
);

  localparam int AW = W + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [W-1:0]  acc;
  logic [CW-1:0] count;
  logic [AW-1:0] base;
  logic [AW-1:0] next;
  logic [AW-1:0] limit;
  logic [CW-1:0] base_count;

  // clear folds into the same cycle as a digit so a line's first digit loads directly.
  always_comb begin
    base       = clear ? '0 : {4'b0, acc};
    base_count = clear ? '0 : count;
    next       = base * AW'(10) + AW'(digit);
`ifdef CALC_PARSER_SIGNED_EN
    limit      = neg ? (AW'(1) << (W - 1)) : ((AW'(1) << (W - 1)) - AW'(1));
`else
    limit      = (AW'(1) << W) - AW'(1);
`endif
    overflow   = (base_count == CW'(MAX_DIGITS)) || (next > limit);
  end

  assign value      = neg ? -acc : acc;
  assign has_digits = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (digit_en && !overflow) begin
      acc   <= next[W-1:0];
      count <= base_count + CW'(1);
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end
  end

endmodule

// File: rtl/calc_cmd_parser.sv
// ASCII "<A><op><B><CR|LF>" line parser producing valid/ready calculator commands.
// Define CALC_PARSER_SIGNED_EN for two's-complement operands with leading '-' signs.
module calc_cmd_parser
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [1:0]   opcode,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic         err,
  output logic [1:0]   err_code
);

  parser_state_e state;
  logic [1:0]    pending;
  logic          neg_reg;

  logic is_digit, is_op, is_term, is_space;
  logic acc_clear, acc_digit_en, acc_ovf, acc_has;
  logic [W-1:0] acc_value;

  always_comb begin
    is_digit     = (rx_data >= ZERO) && (rx_data <= NINE);
    is_op        = (rx_data == PLUS) || (rx_data == MINUS) ||
                   (rx_data == STAR) || (rx_data == SLASH);
    is_term      = (rx_data == CR) || (rx_data == LF);
    is_space     = (rx_data == SPACE);
    acc_clear    = ((state != S_OPA) && (state != S_OPB)) ||
                   ((state == S_OPA) && rx_valid && is_op);
    acc_digit_en = rx_valid && is_digit &&
                   ((state == S_IDLE) || (state == S_OPA) || (state == S_OPB));
  end

  dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_accum (
    .clk        (clk),
    .reset      (reset),
    .clear      (acc_clear),
    .digit_en   (acc_digit_en),
    .digit      (rx_data[3:0]),
    .neg        (neg_reg),
    .value      (acc_value),
    .overflow   (acc_ovf),
    .has_digits (acc_has)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pending   <= ERR_BAD_CHAR;
      neg_reg   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= '0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          neg_reg <= 1'b0;
          if (rx_valid) begin
            if (is_digit) state <= S_OPA;
`ifdef CALC_PARSER_SIGNED_EN
            else if (rx_data == MINUS) begin
              neg_reg <= 1'b1;
              state   <= S_OPA;
            end
`endif
            else if (is_op) begin
              pending <= ERR_MISSING;
              state   <= S_DRAIN;
            end else if (!is_term && !is_space) begin
              pending <= ERR_BAD_CHAR;
              state   <= S_DRAIN;
            end
          end
        end
        S_OPA: begin
          if (rx_valid) begin
            if (is_digit) begin
              if (acc_ovf) begin
                pending <= ERR_OVERFLOW;
                state   <= S_DRAIN;
              end
            end else if (is_op) begin
              // A bare sign with no digits counts as a missing operand.
              if (!acc_has) begin
                pending <= ERR_MISSING;
                state   <= S_DRAIN;
              end else begin
                op_a    <= acc_value;
                opcode  <= op_of(rx_data);
                neg_reg <= 1'b0;
                state   <= S_OPB;
              end
            end else if (is_term) begin
              err      <= 1'b1;
              err_code <= ERR_MISSING;
              state    <= S_IDLE;
            end else if (!is_space) begin
              pending <= ERR_BAD_CHAR;
              state   <= S_DRAIN;
            end
          end
        end
        S_OPB: begin
          if (rx_valid) begin
            if (is_digit) begin
              if (acc_ovf) begin
                pending <= ERR_OVERFLOW;
                state   <= S_DRAIN;
              end
            end else if (is_op) begin
`ifdef CALC_PARSER_SIGNED_EN
              if ((rx_data == MINUS) && !acc_has && !neg_reg) neg_reg <= 1'b1;
              else
`endif
              begin
                pending <= ERR_BAD_CHAR;
                state   <= S_DRAIN;
              end
            end else if (is_term) begin
              if (acc_has) begin
                op_b      <= acc_value;
                cmd_valid <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_MISSING;
                state    <= S_IDLE;
              end
            end else if (!is_space) begin
              pending <= ERR_BAD_CHAR;
              state   <= S_DRAIN;
            end
          end
        end
        S_ISSUE: begin
          // Handshake and overrun are independent: both may happen in one cycle.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (rx_valid) begin
            err      <= 1'b1;
            err_code <= ERR_OVERRUN;
          end
        end
        S_DRAIN: begin
          if (rx_valid && is_term) begin
            err      <= 1'b1;
            err_code <= pending;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
